// File: rtl/serial_comparator_pkg.sv
// Shared types for the digit-serial magnitude comparator: FSM states and the
// one-hot {ST, EQ, LT} result encoding.
package serial_comparator_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Bit order matches the output port order {ST, EQ, LT}.
  typedef logic [2:0] result_t;

  localparam result_t RES_NONE = 3'b000;
  localparam result_t RES_ST   = 3'b100;
  localparam result_t RES_EQ   = 3'b010;
  localparam result_t RES_LT   = 3'b001;

endpackage

// File: rtl/digit_cmp.sv
// Combinational unsigned compare of one DIGIT-wide slice. With sign_bias set,
// the slice MSBs are inverted so a two's-complement top digit orders correctly.
module digit_cmp #(
  parameter int unsigned DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             sign_bias,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [DIGIT-1:0] bias;
  logic [DIGIT-1:0] a_b;
  logic [DIGIT-1:0] b_b;

  always_comb begin
    bias            = '0;
    bias[DIGIT-1]   = sign_bias;
  end

  assign a_b = a ^ bias;
  assign b_b = b ^ bias;

  assign lt = (a_b < b_b);
  assign eq = (a_b == b_b);
  assign gt = (a_b > b_b);

endmodule

// File: rtl/serial_comparator.sv
// Digit-serial magnitude comparator: scans A and B MSB-first, DIGIT bits per
// cycle, with a start/busy/done handshake and optional early exit.
module serial_comparator
  import serial_comparator_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter int unsigned DIGIT      = 4,
  parameter int unsigned EARLY_EXIT = 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  input  logic                           is_signed,
  input  logic [WIDTH-1:0]               A,
  input  logic [WIDTH-1:0]               B,
  output logic                           busy,
  output logic                           done,
  output logic                           ST,
  output logic                           EQ,
  output logic                           LT,
  output logic [$clog2(WIDTH/DIGIT):0]   cycles
);

  localparam int unsigned NDIG = WIDTH / DIGIT;
  localparam int unsigned DW   = $clog2(NDIG);
  localparam int unsigned CW   = DW + 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             signed_q, signed_d;
  logic [DW-1:0]    d_q, d_d;
  logic             decided_q, decided_d;
  result_t          pend_q, pend_d;
  result_t          res_q, res_d;
  logic [CW-1:0]    cycles_q, cycles_d;
  logic             done_q, done_d;

  logic dig_lt, dig_eq, dig_gt;
  logic last_dig;

  digit_cmp #(
    .DIGIT (DIGIT)
  ) u_digit_cmp (
    .a         (a_q[WIDTH-1 -: DIGIT]),
    .b         (b_q[WIDTH-1 -: DIGIT]),
    .sign_bias (signed_q && (d_q == '0)),
    .lt        (dig_lt),
    .eq        (dig_eq),
    .gt        (dig_gt)
  );

  assign last_dig = (d_q == DW'(NDIG - 1));

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    signed_d  = signed_q;
    d_d       = d_q;
    decided_d = decided_q;
    pend_d    = pend_q;
    res_d     = res_q;
    cycles_d  = cycles_q;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d   = RUN;
          a_d       = A;
          b_d       = B;
          signed_d  = is_signed;
          d_d       = '0;
          decided_d = 1'b0;
          pend_d    = RES_EQ;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        // Only the first differing digit decides; later digits cannot override.
        if (!decided_q && !dig_eq) begin
          decided_d = 1'b1;
          pend_d    = dig_lt ? RES_ST : (dig_gt ? RES_LT : RES_EQ);
        end
        a_d = a_q << DIGIT;
        b_d = b_q << DIGIT;
        if ((decided_d && (EARLY_EXIT != 0)) || last_dig) begin
          state_d  = DONE;
          res_d    = pend_d;
          cycles_d = CW'(d_q) + CW'(1);
          done_d   = 1'b1;
        end else begin
          d_d = d_q + DW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      signed_q  <= 1'b0;
      d_q       <= '0;
      decided_q <= 1'b0;
      pend_q    <= RES_NONE;
      res_q     <= RES_NONE;
      cycles_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      signed_q  <= signed_d;
      d_q       <= d_d;
      decided_q <= decided_d;
      pend_q    <= pend_d;
      res_q     <= res_d;
      cycles_q  <= cycles_d;
      done_q    <= done_d;
    end
  end

  assign busy         = (state_q == RUN);
  assign done         = done_q;
  assign {ST, EQ, LT} = res_q;
  assign cycles       = cycles_q;

endmodule

// File: tb/tb_serial_comparator.sv
// Directed bench for serial_comparator: one early-exit instance and one
// full-scan instance share the same stimulus.
module tb_serial_comparator;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [15:0] a = '0;
  logic [15:0] b = '0;

  logic       busy0, done0, st0, eq0, lt0;
  logic [2:0] cyc0;
  logic       busy1, done1, st1, eq1, lt1;
  logic [2:0] cyc1;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  serial_comparator #(
    .WIDTH      (16),
    .DIGIT      (4),
    .EARLY_EXIT (1)
  ) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy0),
    .done      (done0),
    .ST        (st0),
    .EQ        (eq0),
    .LT        (lt0),
    .cycles    (cyc0)
  );

  serial_comparator #(
    .WIDTH      (16),
    .DIGIT      (4),
    .EARLY_EXIT (0)
  ) dut1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .is_signed (is_signed),
    .A         (a),
    .B         (b),
    .busy      (busy1),
    .done      (done1),
    .ST        (st1),
    .EQ        (eq1),
    .LT        (lt1),
    .cycles    (cyc1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Issue one request, wait (bounded) for both instances, check latency and result.
  task automatic run_req(input string tag, input logic [15:0] av, input logic [15:0] bv,
                         input logic sv, input logic [2:0] exp_res, input int exp_c0);
    int lat0 = 0;
    int lat1 = 0;
    a = av; b = bv; is_signed = sv; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      if (done0 && lat0 == 0) lat0 = k;
      if (done1 && lat1 == 0) lat1 = k;
      if (lat0 != 0 && lat1 != 0) break;
    end
    check({tag, " lat0"}, lat0, exp_c0);
    check({tag, " lat1"}, lat1, 4);
    @(posedge clk); #1;
    check({tag, " res0"}, {st0, eq0, lt0}, exp_res);
    check({tag, " cyc0"}, cyc0, exp_c0);
    check({tag, " res1"}, {st1, eq1, lt1}, exp_res);
    check({tag, " cyc1"}, cyc1, 4);
    check({tag, " done0 pulse"}, done0, 0);
    check({tag, " idle"}, {busy0, busy1}, 0);
  endtask

  initial begin
    int n0;
    int n1;

    // Reset
    @(posedge clk); @(posedge clk); #1;
    check("rst busy", {busy0, busy1}, 0);
    check("rst done", {done0, done1}, 0);
    check("rst res", {st0, eq0, lt0, st1, eq1, lt1}, 0);
    check("rst cyc", {cyc0, cyc1}, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_req("eq",     16'h1234, 16'h1234, 1'b0, 3'b010, 4);
    run_req("gt",     16'h5000, 16'h1FFF, 1'b0, 3'b001, 1);
    run_req("neg s",  16'hFFFF, 16'h0001, 1'b1, 3'b100, 1);
    run_req("neg u",  16'hFFFF, 16'h0001, 1'b0, 3'b001, 1);
    run_req("dig2",   16'h0120, 16'h0130, 1'b0, 3'b100, 3);

    // start pulsed mid-RUN is ignored
    a = 16'h1234; b = 16'h1234; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    a = 16'h0001; b = 16'h0002;
    n0 = 0; n1 = 0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (done0) n0++;
      if (done1) n1++;
    end
    check("midrun n0", n0, 1);
    check("midrun n1", n1, 1);
    check("midrun res0", {st0, eq0, lt0}, 3'b010);
    check("midrun res1", {st1, eq1, lt1}, 3'b010);

    // Back-to-back: start held into dut0's DONE cycle
    a = 16'h5000; b = 16'h1FFF; is_signed = 1'b0; start = 1'b1;
    @(posedge clk); #1;                          // E
    a = 16'h0120; b = 16'h0130;
    check("b2b busy E", busy0, 1);
    @(posedge clk); #1;                          // E+1
    check("b2b done1", done0, 1);
    check("b2b busy low", busy0, 0);
    check("b2b res1", {st0, eq0, lt0}, 3'b001);
    check("b2b cyc1", cyc0, 1);
    @(posedge clk); #1;                          // E+2
    start = 1'b0;
    check("b2b busy again", busy0, 1);
    check("b2b done off", done0, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;                          // E+4
    check("b2b busy E+4", busy0, 1);
    check("dut1 b2b done", done1, 1);
    @(posedge clk); #1;                          // E+5
    check("b2b done2", done0, 1);
    check("b2b res2", {st0, eq0, lt0}, 3'b100);
    check("b2b cyc2", cyc0, 3);
    check("dut1 b2b res", {st1, eq1, lt1, cyc1}, {3'b001, 3'd4});
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset mid-RUN
    a = 16'h1234; b = 16'h1234; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("mrst busy", {busy0, busy1}, 0);
    check("mrst done", {done0, done1}, 0);
    check("mrst res", {st0, eq0, lt0, st1, eq1, lt1}, 0);
    check("mrst cyc", {cyc0, cyc1}, 0);
    n0 = 0;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (done0 || done1) n0++;
    end
    check("mrst no done", n0, 0);
    run_req("3v5", 16'h0003, 16'h0005, 1'b0, 3'b100, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_comparator.md
# serial_comparator

Parametrised, digit-serial magnitude comparator. Successor to the team's 4-bit combinational comparator: same ST/EQ/LT result encoding, generalised to any WIDTH, with signed/unsigned mode, a start/busy/done handshake and optional early exit. It examines operands MSB-first, DIGIT bits per cycle, so wide comparisons cost area proportional to DIGIT, not WIDTH.

## Interface
- WIDTH, 16, operand width in bits; WIDTH % DIGIT == 0
- DIGIT, 4, bits compared per cycle; NDIG = WIDTH/DIGIT >= 2
- EARLY_EXIT, 1, 1: finish on first differing digit; 0: always scan all NDIG digits
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- start  in  1  request; sampled on the rising edge, accepted when state != RUN
- is_signed  in  1  1: two's-complement compare; sampled with start
- A  in  WIDTH  operand A; sampled with start
- B  in  WIDTH  operand B; sampled with start
- busy  out  1  high while in RUN
- done  out  1  one-cycle pulse; results valid and updated this cycle
- ST  out  1  A < B
- EQ  out  1  A == B
- LT  out  1  A > B
- cycles  out  $clog2(NDIG)+1  digits examined for the last result (1..NDIG)

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture A, B, is_signed into shift registers, digit index d=0, clear the decided flag → RUN. start=0 → stay.
- RUN: compare the top DIGIT bits of both shift registers, then shift both left by DIGIT.
  - Digit 0 with the is_signed flag: invert the MSB of each digit before the unsigned compare (sign bias). All other digits: plain unsigned.
  - First differing digit sets the decided flag and the pending result (ST or LT). Later digits never override it.
  - Exit to DONE when (decided && EARLY_EXIT) or d == NDIG-1; otherwise d++.
  - All digits equal at d == NDIG-1 → pending result EQ.
  - start during RUN is ignored (not queued).
- DONE: done=1 for exactly this cycle; start=1 → capture a new request, → RUN (back-to-back); else → IDLE.
- ST/EQ/LT are mutually exclusive; exactly one is high after the first done. They and cycles hold their value until the next done.
- Reset (rst_n=0 at an edge, any state, including mid-RUN): state IDLE; busy, done, ST, EQ, LT = 0; cycles = 0; shift registers and d cleared; the in-flight request is discarded with no done pulse.

## Timing
- Request accepted at edge E (start=1, state IDLE or DONE) → busy=1 from E.
- Result decided at digit d → ST/EQ/LT, cycles=d+1 and done are registered at edge E+d+1; done is high for the following cycle only.
- Latency: d+1 edges with EARLY_EXIT=1 and decided; NDIG edges otherwise (EQ always takes NDIG).
- Throughput: a new start in the DONE cycle gives one request per (latency+1) edges; busy drops for exactly that DONE cycle.
- A/B/is_signed need only be stable at the accepting edge.

## Structure
- Package serial_comparator_pkg: state enum typedef (IDLE, RUN, DONE) and result encoding constants (RES_ST, RES_EQ, RES_LT).
- Sub-module digit_cmp: combinational, parameter DIGIT; inputs a, b, sign_bias; outputs lt, eq, gt. Instantiated once in serial_comparator.
- The FSM, shift registers, digit counter and output registers live in serial_comparator.

## Test plan
All with WIDTH=16, DIGIT=4, EARLY_EXIT=1 unless stated.
- Unsigned A=0x1234, B=0x1234 → done at E+4, EQ=1, ST=LT=0, cycles=4.
- Unsigned A=0x5000, B=0x1FFF → done at E+1, LT=1, cycles=1.
- A=0xFFFF, B=0x0001: is_signed=1 → ST=1, cycles=1; is_signed=0 → LT=1, cycles=1.
- A=0x0120, B=0x0130 → ST=1, cycles=3; rerun with EARLY_EXIT=0 → ST=1, cycles=4, done at E+4.
- start pulsed mid-RUN → ignored, exactly one done; start held during the DONE cycle → second request accepted, busy low for one cycle only, second done correct.
- rst_n=0 for one edge mid-RUN → next cycle IDLE, all outputs 0, no done pulse; a subsequent A=3, B=5 request → ST=1.
